serial_adder_pm: RTL and testbench

//  Bit-serial WIDTH-bit adder built around the team's gate-level half-adder cell:
//  two half adders plus an OR form the full-adder bit slice, and a carry flip-flop

---
 rtl/serial_adder_pm.sv | 151 +++++++++++++++
 tb/tb_serial_adder_pm.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_pm.sv
// Bit-serial adder: one full-adder slice (two half adders plus an OR) reused over WIDTH
// cycles, with a carry flip-flop linking successive bit positions.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one operand bit pair added per cycle, LSB first
// DONE  | result just registered; done pulses, start may reload immediately
module serial_adder_pm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // One extra counter bit keeps WIDTH=1 and powers of two from wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] racc_q, racc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] racc_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic slice_s, slice_c;

    half_adder u_ha0 (
        .a (sa_q[0]),
        .b (sb_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (ha1_s),
        .c (ha1_c)
    );

    assign slice_s = ha1_s;
    assign slice_c = ha0_c | ha1_c;

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    always_comb begin
        racc_shift            = racc_q >> 1;
        racc_shift[WIDTH-1]   = slice_s;
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        racc_d  = racc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    racc_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                racc_d  = racc_shift;
                carry_d = slice_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = racc_shift;
                    cout_d  = slice_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            racc_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            racc_q  <= racc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_pm.sv
// Scoreboard bench for serial_adder_pm: an 8-bit and a 1-bit instance, directed vectors
// with hand-computed results, checked by a monitor that tracks busy/done timing and hold.
module tb_serial_adder_pm;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc;
        int         dcyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    exp_t       q8[$];
    exp_t       q1[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] last_sum8 = '0;
    logic       last_cout8 = 1'b0;
    logic       last_sum1 = 1'b0;
    logic       last_cout1 = 1'b0;

    serial_adder_pm #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_pm #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step8();
        logic be, de;
        if (!rst_n) begin
            chk("rst busy8", 32'(busy8), 32'(0));
            chk("rst done8", 32'(done8), 32'(0));
            chk("rst sum8",  32'(sum8),  32'(0));
            chk("rst cout8", 32'(cout8), 32'(0));
            q8.delete();
            last_sum8  = '0;
            last_cout8 = 1'b0;
        end else begin
            be = 1'b0;
            de = 1'b0;
            if (q8.size() > 0) begin
                be = (cyc >= q8[0].acc) && (cyc < q8[0].dcyc);
                de = (cyc == q8[0].dcyc);
            end
            chk("busy8", 32'(busy8), 32'(be));
            chk("done8", 32'(done8), 32'(de));
            if (de) begin
                chk("sum8",  32'(sum8),  32'(q8[0].sum));
                chk("cout8", 32'(cout8), 32'(q8[0].cout));
                last_sum8  = q8[0].sum;
                last_cout8 = q8[0].cout;
                void'(q8.pop_front());
            end else begin
                chk("hold sum8",  32'(sum8),  32'(last_sum8));
                chk("hold cout8", 32'(cout8), 32'(last_cout8));
            end
        end
    endtask

    task automatic step1();
        logic be, de;
        if (!rst_n) begin
            chk("rst busy1", 32'(busy1), 32'(0));
            chk("rst done1", 32'(done1), 32'(0));
            chk("rst sum1",  32'(sum1),  32'(0));
            chk("rst cout1", 32'(cout1), 32'(0));
            q1.delete();
            last_sum1  = 1'b0;
            last_cout1 = 1'b0;
        end else begin
            be = 1'b0;
            de = 1'b0;
            if (q1.size() > 0) begin
                be = (cyc >= q1[0].acc) && (cyc < q1[0].dcyc);
                de = (cyc == q1[0].dcyc);
            end
            chk("busy1", 32'(busy1), 32'(be));
            chk("done1", 32'(done1), 32'(de));
            if (de) begin
                chk("sum1",  32'(sum1),  32'(q1[0].sum));
                chk("cout1", 32'(cout1), 32'(q1[0].cout));
                last_sum1  = q1[0].sum[0];
                last_cout1 = q1[0].cout;
                void'(q1.pop_front());
            end else begin
                chk("hold sum1",  32'(sum1),  32'(last_sum1));
                chk("hold cout1", 32'(cout1), 32'(last_cout1));
            end
        end
    endtask

    // Monitor: samples 1 time unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            step8();
            step1();
        end
    end

    task automatic wait_idle8();
        int n;
        n = 0;
        @(negedge clk);
        while (busy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle8 wait", 32'(busy8), 32'(0));
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        @(negedge clk);
        while (busy1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle1 wait", 32'(busy1), 32'(0));
    endtask

    task automatic push8(input logic [7:0] es, input logic ec);
        exp_t e;
        e.sum  = es;
        e.cout = ec;
        e.acc  = cyc + 1;
        e.dcyc = cyc + 1 + 8;
        q8.push_back(e);
    endtask

    task automatic issue8(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] es, input logic ec);
        wait_idle8();
        a8     = va;
        b8     = vb;
        start8 = 1'b1;
        push8(es, ec);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue1(input logic va, input logic vb, input logic es, input logic ec);
        exp_t e;
        wait_idle1();
        a1     = va;
        b1     = vb;
        start1 = 1'b1;
        e.sum  = {7'b0, es};
        e.cout = ec;
        e.acc  = cyc + 1;
        e.dcyc = cyc + 2;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue8(8'h3C, 8'h55, 8'h91, 1'b0);
        issue8(8'hFF, 8'h01, 8'h00, 1'b1);
        issue8(8'hFF, 8'hFF, 8'hFE, 1'b1);
        issue8(8'h00, 8'h00, 8'h00, 1'b0);

        // Request raised mid-addition must be ignored.
        issue8(8'h10, 8'h20, 8'h30, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'hAA; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;

        // Start held high: reload from each DONE cycle.
        wait_idle8(); a8 = 8'h12; b8 = 8'h34; start8 = 1'b1; push8(8'h46, 1'b0);
        wait_idle8(); a8 = 8'h80; b8 = 8'h80; push8(8'h00, 1'b1);
        wait_idle8(); a8 = 8'hF0; b8 = 8'h0F; push8(8'hFF, 1'b0);
        wait_idle8(); a8 = 8'hC8; b8 = 8'h64; push8(8'h2C, 1'b1);
        @(negedge clk);
        start8 = 1'b0;

        // Reset on the 4th SHIFT edge aborts the addition.
        issue8(8'hFF, 8'hFF, 8'hFE, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue8(8'h01, 8'h02, 8'h03, 1'b0);

        issue1(1'b0, 1'b0, 1'b0, 1'b0);
        issue1(1'b0, 1'b1, 1'b1, 1'b0);
        issue1(1'b1, 1'b0, 1'b1, 1'b0);
        issue1(1'b1, 1'b1, 1'b0, 1'b1);

        n = 0;
        while ((q8.size() > 0 || q1.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", 32'(q8.size() + q1.size()), 32'(0));
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
